// File: rtl/as_mac_alu.sv
// Multi-cycle saturating ALU: ADD/BR in one add cycle, MULADD/MAC via an
// N-cycle shift-add signed multiplier followed by the add cycle.
module as_mac_alu #(
   parameter int N    = 8,
   parameter int FRAC = 7
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [N-1:0] rd_data,
   input  logic [N-1:0] rs_data,
   input  logic [N-1:0] immediate,
   input  logic [N:0]   switches,
   input  logic         in_en,
   output logic         busy,
   output logic         done,
   output logic         z,
   output logic         neg,
   output logic         v,
   output logic [N-1:0] w_data,
   output logic [N-1:0] acc_out
);
   localparam int CW = $clog2(N);
   localparam logic [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_ADD, S_DONE} state_t;
   state_t state_q, state_d;

   logic [1:0]     op_q;
   logic [N-1:0]   a_q, imm_q;
   logic           br_q;
   logic [N-1:0]   mpl_q, mpl_d;
   logic [2*N-1:0] mcand_q, mcand_d, prod_q, prod_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   res_q, res_d, acc_q, acc_d;
   logic           z_q, z_d, neg_q, neg_d, v_q, v_d;

   logic           accept, mul_op, mul_ovf, add_ovf;
   logic [2*N-1:0] shifted;
   logic [N-1:0]   msat, opa, opb, sat_sum;
   logic [N:0]     sum;

   assign accept = (state_q == S_IDLE) && start;
   assign mul_op = op_q[1] ^ op_q[0];

   always_comb begin : fsm_next
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = (op[1] ^ op[0]) ? S_MUL : S_ADD;
         S_MUL:   if (cnt_q == CW'(N-1)) state_d = S_ADD;
         S_ADD:   state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // One partial product per cycle; the multiplier MSB carries negative weight.
   always_comb begin : mul_step
      mcand_d = mcand_q;
      mpl_d   = mpl_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
      if (accept) begin
         mcand_d = {{N{rs_data[N-1]}}, rs_data};
         mpl_d   = immediate;
         prod_d  = '0;
         cnt_d   = '0;
      end else if (state_q == S_MUL) begin
         if (mpl_q[0])
            prod_d = (cnt_q == CW'(N-1)) ? prod_q - mcand_q : prod_q + mcand_q;
         mcand_d = mcand_q << 1;
         mpl_d   = mpl_q >> 1;
         cnt_d   = cnt_q + CW'(1);
      end
   end

   always_comb begin : sat_path
      shifted = $signed(prod_q) >>> FRAC;
      mul_ovf = !((&shifted[2*N-1:N-1]) || !(|shifted[2*N-1:N-1]));
      msat    = mul_ovf ? (shifted[2*N-1] ? MINV : MAXV) : shifted[N-1:0];
      unique case (op_q)
         2'b00:   begin opa = a_q;         opb = imm_q; end
         2'b01:   begin opa = a_q;         opb = msat;  end
         2'b10:   begin opa = acc_q;       opb = msat;  end
         default: begin opa = {N{br_q}};   opb = imm_q; end
      endcase
      sum     = {opa[N-1], opa} + {opb[N-1], opb};
      add_ovf = sum[N] ^ sum[N-1];
      sat_sum = add_ovf ? (sum[N] ? MINV : MAXV) : sum[N-1:0];
   end

   always_comb begin : result_next
      res_d = res_q;
      acc_d = acc_q;
      z_d   = z_q;
      neg_d = neg_q;
      v_d   = v_q;
      if (state_q == S_ADD) begin
         res_d = sat_sum;
         acc_d = sat_sum;
         z_d   = (sat_sum == '0);
         neg_d = sat_sum[N-1];
         v_d   = add_ovf | (mul_op & mul_ovf);
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         imm_q   <= '0;
         br_q    <= 1'b0;
         mpl_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         acc_q   <= '0;
         z_q     <= 1'b0;
         neg_q   <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q  <= op;
            a_q   <= rd_data;
            imm_q <= immediate;
            br_q  <= switches[N];
         end
         mpl_q   <= mpl_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         acc_q   <= acc_d;
         z_q     <= z_d;
         neg_q   <= neg_d;
         v_q     <= v_d;
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign z       = z_q;
   assign neg     = neg_q;
   assign v       = v_q;
   assign acc_out = acc_q;
   assign w_data  = in_en ? switches[N-1:0] : res_q;

endmodule

// File: tb/tb_as_mac_alu.sv
// Bench for as_mac_alu: integer reference model checked every cycle, plus
// directed operations with hand-computed results and latencies.
module tb_as_mac_alu;
   localparam int N    = 8;
   localparam int FRAC = 7;

   logic         clk = 1'b0;
   logic         n_reset = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   op = '0;
   logic [N-1:0] rd_data = '0, rs_data = '0, immediate = '0;
   logic [N:0]   switches = '0;
   logic         in_en = 1'b0;
   logic         busy, done, z, neg, v;
   logic [N-1:0] w_data, acc_out;

   int n_pass = 0;
   int n_chk  = 0;

   as_mac_alu #(.N(N), .FRAC(FRAC)) dut (
      .clk(clk), .n_reset(n_reset), .start(start), .op(op),
      .rd_data(rd_data), .rs_data(rs_data), .immediate(immediate),
      .switches(switches), .in_en(in_en),
      .busy(busy), .done(done), .z(z), .neg(neg), .v(v),
      .w_data(w_data), .acc_out(acc_out)
   );

   always #5 clk = ~clk;

   function automatic int clamp(int x);
      int lo, hi;
      lo = -(1 << (N-1));
      hi = (1 << (N-1)) - 1;
      return (x > hi) ? hi : (x < lo) ? lo : x;
   endfunction

   function automatic int mask(int x);
      return x & ((1 << N) - 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference model: countdown to done; result applied one cycle before done.
   int m_rem = 0, m_res = 0, m_acc = 0;
   bit m_z = 0, m_neg = 0, m_v = 0;
   int c_op, c_rd, c_rs, c_imm, c_br;
   int p, ms, ma, mb, ms_sum, mr;
   bit mv, mulop;

   always @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         m_rem = 0; m_res = 0; m_acc = 0; m_z = 0; m_neg = 0; m_v = 0;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 1) begin
            p      = c_rs * c_imm;
            ms     = p >>> FRAC;
            mv     = (ms != clamp(ms));
            ms     = clamp(ms);
            mulop  = (c_op == 1) || (c_op == 2);
            ma     = (c_op == 2) ? m_acc : (c_op == 3) ? (c_br != 0 ? -1 : 0) : c_rd;
            mb     = (c_op == 0 || c_op == 3) ? c_imm : ms;
            ms_sum = ma + mb;
            mr     = clamp(ms_sum);
            m_v    = (mulop && mv) || (ms_sum != mr);
            m_res  = mr;
            m_acc  = mr;
            m_z    = (mr == 0);
            m_neg  = (mr < 0);
         end
      end else if (start) begin
         c_op  = int'(op);
         c_rd  = int'($signed(rd_data));
         c_rs  = int'($signed(rs_data));
         c_imm = int'($signed(immediate));
         c_br  = int'(switches[N]);
         m_rem = (op == 2'b01 || op == 2'b10) ? N + 2 : 2;
      end
   end

   always @(negedge clk) begin : compare
      int exp_w;
      exp_w = in_en ? int'(switches[N-1:0]) : mask(m_res);
      chk("busy",    int'(busy),    int'(m_rem > 0));
      chk("done",    int'(done),    int'(m_rem == 1));
      chk("acc_out", int'(acc_out), mask(m_acc));
      chk("w_data",  int'(w_data),  exp_w);
      chk("z",       int'(z),       int'(m_z));
      chk("neg",     int'(neg),     int'(m_neg));
      chk("v",       int'(v),       int'(m_v));
   end

   task automatic run_op(input string name, input logic [1:0] o, input int a,
                         input int b_rs, input int b_imm, input logic br,
                         input int glitch_k, input int exp_lat, input int exp_res,
                         input logic exp_v);
      int lat;
      lat = 0;
      @(posedge clk); #2;
      op = o; rd_data = N'(a); rs_data = N'(b_rs); immediate = N'(b_imm);
      switches = {br, switches[N-1:0]}; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      rd_data = N'($urandom); rs_data = N'($urandom); immediate = N'($urandom);
      switches = (N+1)'($urandom); op = 2'($urandom);
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(negedge clk);
         if (done) lat = k;
         if (glitch_k != 0 && k == glitch_k)     begin #1 start = 1'b1; op = 2'b00; end
         if (glitch_k != 0 && k == glitch_k + 1) begin #1 start = 1'b0; end
      end
      chk({name, "_latency"}, lat, exp_lat);
      chk({name, "_res"}, int'(w_data), mask(exp_res));
      chk({name, "_v"}, int'(v), int'(exp_v));
   endtask

   initial begin : stim
      int dcount;
      #1 n_reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_acc",  int'(acc_out), 0);
      chk("reset_v",    int'(v), 0);
      @(posedge clk); #2 n_reset = 1'b1;

      run_op("add_5_3", 2'b00, 5, 0, 3, 1'b0, 0, 2, 8, 1'b0);
      chk("add_5_3_acc", int'(acc_out), 8);
      chk("add_5_3_z",   int'(z), 0);
      chk("add_5_3_neg", int'(neg), 0);
      run_op("add_pos_sat", 2'b00, 100, 0, 100, 1'b0, 0, 2, 127, 1'b1);
      run_op("add_neg_sat", 2'b00, -100, 0, -100, 1'b0, 0, 2, -128, 1'b1);
      chk("add_neg_sat_neg", int'(neg), 1);
      run_op("muladd_42", 2'b01, 10, 64, 64, 1'b0, 0, 10, 42, 1'b0);
      run_op("muladd_floor", 2'b01, 0, -64, 3, 1'b0, 0, 10, -2, 1'b0);
      chk("muladd_floor_neg", int'(neg), 1);
      run_op("muladd_msat", 2'b01, 0, -128, -128, 1'b0, 0, 10, 127, 1'b1);
      run_op("mac_sat", 2'b10, 0, 64, 64, 1'b0, 0, 10, 127, 1'b1);
      run_op("br_one", 2'b11, 0, 0, 1, 1'b1, 0, 2, 0, 1'b0);
      chk("br_one_z", int'(z), 1);
      run_op("br_zero", 2'b11, 0, 0, 5, 1'b0, 0, 2, 5, 1'b0);

      @(posedge clk); #2;
      in_en = 1'b1; switches = {1'b0, N'(8'hA5)};
      @(negedge clk);
      chk("in_en_wdata", int'(w_data), 'hA5);
      chk("in_en_acc",   int'(acc_out), 5);
      @(posedge clk); #2 in_en = 1'b0;

      run_op("glitch", 2'b01, 10, 64, 64, 1'b0, 3, 10, 42, 1'b0);
      dcount = 0;
      for (int k = 0; k < N + 4; k++) begin
         @(negedge clk);
         if (done) dcount++;
      end
      chk("glitch_single_done", dcount, 0);

      @(posedge clk); #2;
      op = 2'b01; rd_data = N'(10); rs_data = N'(64); immediate = N'(64); start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      repeat (4) @(negedge clk);
      #1 n_reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_acc",  int'(acc_out), 0);
      @(posedge clk); #2 n_reset = 1'b1;
      dcount = 0;
      for (int k = 0; k < N + 4; k++) begin
         @(negedge clk);
         if (done) dcount++;
      end
      chk("rst_mid_no_done", dcount, 0);

      run_op("after_rst", 2'b00, 5, 0, 3, 1'b0, 0, 2, 8, 1'b0);
      run_op("mac_neg", 2'b10, 0, 64, -64, 1'b0, 0, 10, -24, 1'b0);

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
